// File: rtl/safecrack_pkg.sv
// Shared definitions for the safecrack auto-dialer.
//   DIGIT_W    : width of one dial digit (the lock has four buttons, 0..3)
//   CODE_W     : width of a full three-digit code {d0,d1,d2}
//   CODE_COUNT : number of distinct codes the dialer walks through
//   state_e    : top-level search FSM states
//   code_digit : extracts digit idx of a code (idx 0 is pressed first)
package safecrack_pkg;

  localparam int DIGIT_W    = 2;
  localparam int CODE_W     = 3 * DIGIT_W;
  localparam int CODE_COUNT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WAIT_RESP,
    S_WAIT_LOCK,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                    input logic [1:0]        idx);
    logic [DIGIT_W-1:0] d;
    case (idx)
      2'd0:    d = code[5:4];
      2'd1:    d = code[3:2];
      default: d = code[1:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/safecrack_autodialer_btn_pulse_gen.sv
// Button press/gap sequencer.
// A fire request starts a press of one button (btn_n low on the selected bit)
// for PRESS_CYCLES cycles followed by a release gap of GAP_CYCLES cycles.
// With gap_only set, fire starts the release gap directly without pressing.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : abandon any press/gap immediately (buttons released next edge)
//   fire       : start a new press (or a bare gap when gap_only is set)
//   gap_only   : qualifies fire
//   digit      : button to press
//   btn_n      : registered active-low button drive
//   pulse_done : high in the last cycle of the current press or gap phase
module btn_pulse_gen
  import safecrack_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               fire,
  input  logic               gap_only,
  input  logic [DIGIT_W-1:0] digit,
  output logic [3:0]         btn_n,
  output logic               pulse_done
);

  localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {P_IDLE, P_PRESS, P_GAP} phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       btn_n_q, btn_n_d;

  always_comb begin
    pulse_done = ((phase_q == P_PRESS) && (cnt_q == CNT_W'(PRESS_CYCLES - 1))) ||
                 ((phase_q == P_GAP)   && (cnt_q == CNT_W'(GAP_CYCLES - 1)));
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    phase_d = phase_q;
    cnt_d   = cnt_q;
    btn_n_d = btn_n_q;
    if (clear) begin
      phase_d = P_IDLE;
      cnt_d   = '0;
      btn_n_d = 4'hF;
    end else if (fire) begin
      // A new fire wins over the gap that is just finishing, so presses chain back to back.
      cnt_d = '0;
      if (gap_only) begin
        phase_d = P_GAP;
        btn_n_d = 4'hF;
      end else begin
        phase_d = P_PRESS;
        btn_n_d = ~(4'b0001 << digit);
      end
    end else if (pulse_done) begin
      cnt_d   = '0;
      btn_n_d = 4'hF;
      phase_d = (phase_q == P_PRESS) ? P_GAP : P_IDLE;
    end else if (phase_q != P_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: btn_n resets asynchronously so a reset mid-press releases the button without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= P_IDLE;
      cnt_q   <= '0;
      btn_n_q <= 4'hF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      btn_n_q <= btn_n_d;
    end
  end

  assign btn_n = btn_n_q;

endmodule

// File: rtl/safecrack_autodialer.sv
// Brute-force auto-dialer for a three-digit, four-button combination lock.
// Walks codes 0..63, pressing d0,d1,d2 of each, then watches the lock LEDs:
// green means the code opened the lock, red means lockout (wait it out plus
// one gap), silence means try the next code.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : begin a search from code 0 (ignored while busy)
//   abort                : stop the search at once (wins over everything)
//   led_green, led_red   : lock status LEDs, same clock domain
//   btn_n                : active-low button drive, bit d is digit d
//   busy                 : search in progress
//   done, found          : search finished / winning code located
//   code_out             : current or winning code {d0,d1,d2}
//   attempts             : number of codes fully entered, 0..64
module safecrack_autodialer
  import safecrack_pkg::*;
#(
  parameter int PRESS_CYCLES     = 4,
  parameter int GAP_CYCLES       = 4,
  parameter int RESP_WAIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              led_green,
  input  logic              led_red,
  output logic [3:0]        btn_n,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CODE_W-1:0] code_out,
  output logic [6:0]        attempts
);

  localparam int MAX_PG  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_PG > RESP_WAIT_CYCLES) ? MAX_PG : RESP_WAIT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [1:0]         idx_q, idx_d;
  logic [6:0]         attempts_q, attempts_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic               lock_gap_q, lock_gap_d;  // current S_GAP follows a lockout, not a press
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fire, gap_only, clear, advance, pulse_done;
  logic [DIGIT_W-1:0] fire_digit;

  assign busy = state_q inside {S_PRESS, S_GAP, S_WAIT_RESP, S_WAIT_LOCK};

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    attempts_d = attempts_q;
    done_d     = done_q;
    found_d    = found_q;
    lock_gap_d = lock_gap_q;
    fire       = 1'b0;
    gap_only   = 1'b0;
    clear      = 1'b0;
    advance    = 1'b0;
    fire_digit = code_digit(code_q, idx_q);

    if (abort) begin
      // Outside a search abort only masks start; done/found stay as reported.
      if (busy) begin
        state_d    = S_IDLE;
        done_d     = 1'b0;
        found_d    = 1'b0;
        lock_gap_d = 1'b0;
        clear      = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state_d    = S_PRESS;
            code_d     = '0;
            idx_d      = '0;
            attempts_d = '0;
            done_d     = 1'b0;
            found_d    = 1'b0;
            fire       = 1'b1;
            fire_digit = '0;
          end
        end
        S_PRESS: begin
          if (pulse_done) state_d = S_GAP;
        end
        S_GAP: begin
          if (pulse_done) begin
            if (lock_gap_q) begin
              lock_gap_d = 1'b0;
              advance    = 1'b1;
            end else if (idx_q < 2'd2) begin
              idx_d      = idx_q + 2'd1;
              state_d    = S_PRESS;
              fire       = 1'b1;
              fire_digit = code_digit(code_q, idx_q + 2'd1);
            end else begin
              attempts_d = attempts_q + 7'd1;
              state_d    = S_WAIT_RESP;
            end
          end
        end
        S_WAIT_RESP: begin
          if (led_green) begin
            state_d = S_FOUND;
            done_d  = 1'b1;
            found_d = 1'b1;
          end else if (led_red) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == CNT_W'(RESP_WAIT_CYCLES - 1)) begin
            advance = 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (!led_red) begin
            state_d    = S_GAP;
            lock_gap_d = 1'b1;
            fire       = 1'b1;
            gap_only   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        if (code_q == CODE_W'(CODE_COUNT - 1)) begin
          state_d = S_EXHAUSTED;
          done_d  = 1'b1;
          found_d = 1'b0;
          code_d  = CODE_W'(CODE_COUNT - 1);
        end else begin
          code_d     = code_q + 1'b1;
          idx_d      = '0;
          state_d    = S_PRESS;
          fire       = 1'b1;
          fire_digit = code_digit(code_q + 1'b1, 2'd0);
        end
      end
    end

    // Restarts at zero on every state change; saturates during an unbounded lockout.
    if (state_d != state_q)                    cnt_d = '0;
    else if (cnt_q == CNT_W'(MAX_CYC - 1))     cnt_d = cnt_q;
    else                                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      idx_q      <= '0;
      attempts_q <= '0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      lock_gap_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      attempts_q <= attempts_d;
      done_q     <= done_d;
      found_q    <= found_d;
      lock_gap_q <= lock_gap_d;
      cnt_q      <= cnt_d;
    end
  end

  btn_pulse_gen #(
    .PRESS_CYCLES (PRESS_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_btn_pulse_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fire       (fire),
    .gap_only   (gap_only),
    .digit      (fire_digit),
    .btn_n      (btn_n),
    .pulse_done (pulse_done)
  );

  assign done     = done_q;
  assign found    = found_q;
  assign code_out = code_q;
  assign attempts = attempts_q;

endmodule

// File: doc/safecrack_autodialer.md
SAFECRACK_AUTODIALER -- requirements
Module: safecrack_autodialer

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 4: cycles each button is held low.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: cycles all buttons are released between presses and after a lockout.
REQ-003 SHALL have parameter RESP_WAIT_CYCLES, default 16: response window after the third press of a code.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin a search from code 0.
REQ-007 SHALL have port abort, input, 1: stops the search immediately.
REQ-008 SHALL have port led_green, input, 1: lock unlocked indication, same clk domain.
REQ-009 SHALL have port led_red, input, 1: lock lockout indication, same clk domain.
REQ-010 SHALL have port btn_n, output, 4: active-low button drive to the lock; bit d means digit d.
REQ-011 SHALL have port busy, output, 1: search in progress.
REQ-012 SHALL have port done, output, 1: search finished; held until next start.
REQ-013 SHALL have port found, output, 1: valid with done; 1 means the code was accepted.
REQ-014 SHALL have port code_out, output, 6: current or winning code as {d0,d1,d2}, each 2 bits; d0 is pressed first.
REQ-015 SHALL have port attempts, output, 7: number of completed codes, 0..64.

Function
REQ-016 SHALL implement the states S_IDLE, S_PRESS, S_GAP, S_WAIT_RESP, S_WAIT_LOCK, S_FOUND and S_EXHAUSTED.
REQ-017 When start is sampled in S_IDLE, S_FOUND or S_EXHAUSTED, the block SHALL clear code_out, attempts, done and found, and enter S_PRESS so that btn_n drops on the next cycle.
REQ-018 In S_PRESS, btn_n SHALL equal ~(4'b0001 << digit) for exactly PRESS_CYCLES cycles, where digit is the code_out field selected by the 2-bit digit index; the block then enters S_GAP.
REQ-019 In S_GAP, btn_n SHALL be 4'hF for exactly GAP_CYCLES cycles; exit is to S_PRESS with digit index+1 if the index is less than 2; otherwise attempts SHALL increment and the block SHALL enter S_WAIT_RESP.
REQ-020 In S_WAIT_RESP, btn_n SHALL be 4'hF and led_green/led_red SHALL be sampled every cycle for at most RESP_WAIT_CYCLES cycles.
REQ-021 In S_WAIT_RESP, led_green high SHALL cause a transition to S_FOUND, and green SHALL take priority if green and red are high in the same cycle.
REQ-022 In S_WAIT_RESP, led_red high SHALL cause a transition to S_WAIT_LOCK.
REQ-023 If the S_WAIT_RESP window expires with no response, the block SHALL go to S_EXHAUSTED if code_out equals 63; otherwise code_out SHALL increment, the digit index SHALL reset to 0, and the block SHALL enter S_PRESS.
REQ-024 In S_WAIT_LOCK, the block SHALL wait, without a bound, for led_red to go low, then do one S_GAP period, then advance the code as in REQ-023, with no press issued before the gap ends.
REQ-025 On entry to S_FOUND, the block SHALL set done=1 and found=1 and hold code_out.
REQ-026 On entry to S_EXHAUSTED, the block SHALL set done=1, found=0 and code_out=63.
REQ-027 busy SHALL be 1 exactly in S_PRESS, S_GAP, S_WAIT_RESP and S_WAIT_LOCK.
REQ-028 start SHALL be ignored while busy.
REQ-029 abort SHALL take priority over start and over all transitions.
REQ-030 abort while busy SHALL give btn_n=4'hF and state S_IDLE on the next edge, with done=0 and found=0, and attempts holding its value.
REQ-031 led_green or led_red asserted outside S_WAIT_RESP/S_WAIT_LOCK SHALL be ignored.
REQ-032 The internal cycle counter SHALL be sized for max(PRESS_CYCLES, GAP_CYCLES, RESP_WAIT_CYCLES) and SHALL be cleared on every state change.
REQ-033 At most one btn_n bit SHALL be low in any cycle.

Reset
REQ-034 While rst is high, the block SHALL hold state=S_IDLE, btn_n=4'hF, busy=0, done=0, found=0, code_out=0, attempts=0, with all counters at 0.
REQ-035 Reset asserted mid-press SHALL release btn_n asynchronously.

Structure
REQ-036 The state enum, the digit width (2) and the code count (64) SHALL live in the shared package safecrack_pkg.
REQ-037 The press/gap timing SHALL be a sub-module btn_pulse_gen (inputs: fire, digit; outputs: btn_n, pulse_done), which btn_pulse_gen SHALL own.

Verification
REQ-038 Lock model opens on code 6'b10_01_11 with defaults; start -> press pattern 0,0,0 ... 2,1,3; found=1, done=1, code_out=39, attempts=40.
REQ-039 Lock model never opens -> 64 codes; done=1, found=0, code_out=63, attempts=64, busy low.
REQ-040 Red raised for 100 cycles after attempts 3 -> no btn_n low during red or the following 4 cycles; code 3 pressed next.
REQ-041 abort during the second press of code 5 -> btn_n=4'hF next cycle, S_IDLE, done=0, attempts=5.
REQ-042 Green and red high in the same cycle of S_WAIT_RESP -> found=1.
REQ-043 start pulsed while busy -> no effect.
REQ-044 rst mid-S_GAP -> all outputs at reset values.
REQ-045 A checker SHALL assert that every press is exactly 4 cycles low and that at most one btn_n bit is low at any time.
